onehot_decoder_seq: RTL
=======================

Name: onehot_decoder_seq

Overview:
- Sequenced 3-to-8 one-hot decoder. It is the receive-side counterpart of the 8-to-3 encoder.
- Accepts a stream of 3-bit codes through a valid/ready handshake and buffers them in a small FIFO.
- Drives each decoded one-hot pattern on Data_out for a fixed number of cycles, e.g. to strobe one of eight select lines in turn.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot pattern stays on Data_out; legal range is 1..255.
- DEPTH, 4, input FIFO depth in entries; must be a power of two, at least 2.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Code_in  input  3  encoded input; bit index of the one-hot bit to drive.
- Code_valid  input  1  Code_in is valid this cycle.
- Code_ready  output  1  FIFO can accept a code this cycle.
- Enable  input  1  permits popping a new code from the FIFO.
- Data_out  output  8  registered one-hot decoded output, or all zero.
- Busy  output  1  high while a pattern is being held (state HOLD).
- Done  output  1  one-cycle pulse on the final cycle of each hold period.
- Level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset, sampled at a Clk edge with Reset=1:
  - Data_out=8'b0, Busy=0, Done=0, Level=0, Code_ready=1 in the following cycle.
  - FIFO is emptied and the FSM goes to IDLE.
  - Reset mid-hold aborts immediately: Data_out clears at that edge and no Done pulse is issued.
- Push:
  - Code_ready = (Level != DEPTH), purely combinational from registered Level.
  - Push occurs when Code_valid && Code_ready at a rising edge.
  - When full, Code_ready is 0 even if a pop happens in the same cycle (no pass-through-when-full).
  - Code_in must be held stable while Code_valid=1 && Code_ready=0.
- FIFO: registered storage. A code pushed at edge t is first poppable at edge t+1. Simultaneous push and pop updates Level by +0. Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, HOLD.
  - IDLE:
    - Data_out=0, Busy=0.
    - If Level!=0 && Enable at an edge: pop the head code c, load Data_out = 8'b1 << c, load the hold counter with HOLD_CYCLES-1, and go to HOLD.
  - HOLD:
    - Busy=1, Data_out unchanged.
    - If counter != 0: decrement.
    - If counter == 0: Done=1 during this cycle. At the edge, if Level!=0 && Enable, pop the next code and reload Data_out and the counter (back-to-back, no zero gap, stay in HOLD). Otherwise set Data_out=0 and go to IDLE.
- Timing and latency:
  - Each pattern is visible for exactly HOLD_CYCLES cycles.
  - A code pushed at edge t, with the FSM IDLE and Enable=1, appears on Data_out after edge t+1.
- Enable:
  - Deasserting Enable never truncates a hold; it only blocks pops.
  - Codes remain queued while Enable=0.
- HOLD_CYCLES=1: a pattern lasts one cycle. Done is high on every HOLD cycle; back-to-back codes give a new pattern every cycle.
- Data_out is always either all-zero or exactly one bit set. It is never multi-hot or X after reset.
- Done is asserted only in HOLD with counter==0; it is 0 in IDLE.

Test Plan:
- Reset, then push codes 0..7 consecutively with Enable=1 and HOLD_CYCLES=4 -> Data_out sequence is 8'h01, 02, 04, 08, 10, 20, 40, 80, each for exactly 4 cycles with no gaps; 8 Done pulses; Data_out=0 and Busy=0 after the last pulse.
- With Enable=0, push codes until Code_ready=0 -> exactly DEPTH=4 pushes accepted and Level=4; a fifth Code_valid stalls with Code_in held. Raise Enable -> first pop frees a slot and the stalled code is accepted the next cycle.
- Single push of code 5 into an idle block -> Data_out=8'h20 starting one cycle after the accepting edge; Busy high for 4 cycles; Done on the 4th cycle; Data_out=0 afterwards.
- Push code 3 and assert Reset on the 2nd hold cycle -> next cycle Data_out=0, Busy=0, Level=0, no Done pulse, Code_ready=1.
- Compile with HOLD_CYCLES=1 and stream codes 7, 0, 2 on consecutive cycles -> Data_out = 8'h80, 01, 04 on consecutive cycles; Done high on all three.
- Deassert Enable mid-hold with 2 codes queued -> current pattern completes its full hold, then Data_out=0 and Level stays 2. Re-enable -> patterns resume in FIFO order.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 one-hot decoder: codes arrive over valid/ready into a small FIFO,
// and each decoded pattern is held on Data_out for HOLD_CYCLES cycles.
module onehot_decoder_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [2:0]               Code_in,
  input  logic                     Code_valid,
  output logic                     Code_ready,
  input  logic                     Enable,
  output logic [7:0]               Data_out,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(DEPTH):0]   Level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          push, pop, cnt_zero;

  // Ready depends only on registered occupancy, so a full FIFO never passes through.
  assign Code_ready = (level_q != LW'(DEPTH));
  assign push       = Code_valid && Code_ready;
  assign cnt_zero   = (cnt_q == '0);
  assign pop        = Enable && (level_q != '0) && ((state_q == IDLE) || cnt_zero);
  assign Level      = level_q;

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= Code_in;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = HOLD;
          cnt_d   = HOLD_M1;
          data_d  = 8'b1 << mem[rd_ptr];
        end
      end
      HOLD: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (pop) begin
          cnt_d  = HOLD_M1;
          data_d = 8'b1 << mem[rd_ptr];
        end else begin
          state_d = IDLE;
          data_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
      end
    endcase
  end

  always_comb begin
    Data_out = data_q;
    Busy     = (state_q == HOLD);
    Done     = (state_q == HOLD) && cnt_zero;
  end

endmodule
